// File: rtl/tx_bit_sequencer.sv
// Serial frame bit sequencer: start, LSB-first data, optional parity, stop bits, paced by baud_tick.
// Optional parity state/logic is compiled in when TX_BIT_SEQ_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for frame_ready together with baud_tick
// START  | start bit (line low)
// DATA   | data bits, LSB first
// PARITY | parity bit (TX_BIT_SEQ_PARITY_EN builds only)
// STOP   | stop bit(s), line high
module tx_bit_sequencer #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 frame_ready,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 frame_ack,
    output logic                 busy,
    output logic [3:0]           bit_select,
    output logic                 tx_bit,
    output logic                 frame_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("tx_bit_sequencer: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("tx_bit_sequencer: STOP_BITS must be 1 or 2");
    end

`ifdef TX_BIT_SEQ_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_BITS + 1);
    localparam logic [3:0] STOP_SPAN     = 4'(STOP_BITS);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_select;
    logic                 r_tx_bit;
    logic                 r_busy;

    logic                 w_par_on;
    logic [3:0]           w_last_stop_idx;
    logic                 w_stop_end;
    logic                 w_accept;

`ifdef TX_BIT_SEQ_PARITY_EN
    logic r_par_en;
    logic r_parity;
    assign w_par_on = r_par_en;
`else
    logic w_unused_parity;
    assign w_unused_parity = parity_en ^ parity_odd;
    assign w_par_on        = 1'b0;
`endif

    assign w_last_stop_idx = LAST_DATA_IDX + STOP_SPAN + {3'b000, w_par_on};
    assign w_stop_end      = (r_state == STOP) && baud_tick && (r_bit_select == w_last_stop_idx);
    // The final stop tick doubles as an acceptance slot so frames run back-to-back.
    assign w_accept        = baud_tick && frame_ready && ((r_state == IDLE) || w_stop_end);

    assign frame_ack  = w_accept && !reset;
    assign frame_done = w_stop_end && !reset;
    assign busy       = r_busy;
    assign bit_select = r_bit_select;
    assign tx_bit     = r_tx_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_select <= 4'd0;
            r_tx_bit     <= 1'b1;
            r_busy       <= 1'b0;
`ifdef TX_BIT_SEQ_PARITY_EN
            r_par_en     <= 1'b0;
            r_parity     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state      <= START;
            r_shift      <= data_in;
            r_bit_select <= 4'd1;
            r_tx_bit     <= 1'b0;
            r_busy       <= 1'b1;
`ifdef TX_BIT_SEQ_PARITY_EN
            r_par_en     <= parity_en;
            r_parity     <= (^data_in) ^ parity_odd;
`endif
        end else if (baud_tick) begin
            case (r_state)
                IDLE: begin
                end
                START: begin
                    r_state      <= DATA;
                    r_bit_select <= r_bit_select + 4'd1;
                    r_tx_bit     <= r_shift[0];
                end
                DATA: begin
                    r_bit_select <= r_bit_select + 4'd1;
                    if (r_bit_select == LAST_DATA_IDX) begin
`ifdef TX_BIT_SEQ_PARITY_EN
                        if (r_par_en) begin
                            r_state  <= PARITY;
                            r_tx_bit <= r_parity;
                        end else
`endif
                        begin
                            r_state  <= STOP;
                            r_tx_bit <= 1'b1;
                        end
                    end else begin
                        r_tx_bit <= r_shift[1];
                        r_shift  <= r_shift >> 1;
                    end
                end
`ifdef TX_BIT_SEQ_PARITY_EN
                PARITY: begin
                    r_state      <= STOP;
                    r_bit_select <= r_bit_select + 4'd1;
                    r_tx_bit     <= 1'b1;
                end
`endif
                STOP: begin
                    if (w_stop_end) begin
                        r_state      <= IDLE;
                        r_bit_select <= 4'd0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_bit_select <= r_bit_select + 4'd1;
                    end
                    r_tx_bit <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_bit_sequencer.sv
// Bench for tx_bit_sequencer: table-driven frames checked against a per-bit scoreboard model,
// plus back-to-back, mid-frame reset and a 5-data/2-stop instance.
module tb_tx_bit_sequencer;

`ifdef TX_BIT_SEQ_PARITY_EN
    localparam int PAR_BUILT = 1;
`else
    localparam int PAR_BUILT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick, frame_ready, parity_en, parity_odd;
    logic [7:0] data_in;
    logic       frame_ack, busy, tx_bit, frame_done;
    logic [3:0] bit_select;

    logic       t2, r2;
    logic [4:0] d2;
    logic       ack2, busy2, tx2, done2;
    logic [3:0] bs2;

    always #5 clk = ~clk;

    tx_bit_sequencer #(.DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .frame_ready(frame_ready),
        .data_in(data_in), .parity_en(parity_en), .parity_odd(parity_odd),
        .frame_ack(frame_ack), .busy(busy), .bit_select(bit_select),
        .tx_bit(tx_bit), .frame_done(frame_done)
    );

    tx_bit_sequencer #(.DATA_BITS(5), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .baud_tick(t2), .frame_ready(r2),
        .data_in(d2), .parity_en(1'b0), .parity_odd(1'b0),
        .frame_ack(ack2), .busy(busy2), .bit_select(bs2),
        .tx_bit(tx2), .frame_done(done2)
    );

    typedef struct {
        logic [7:0] data;
        bit         pe;
        bit         po;
        int         exp_len;
        bit         exp_par;
    } vec_t;

    typedef struct {
        logic [3:0] bs;
        logic       tx;
    } sb_t;

    vec_t vecs[6];
    sb_t  sb_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_ack    = 0;
    int   n_done   = 0;

    logic [3:0] m_bs   = 4'd0;
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input bit pe, input bit po);
        sb_t it;
        bit  par;
        par   = (PAR_BUILT != 0) && pe;
        it.bs = 4'd1; it.tx = 1'b0; sb_q.push_back(it);
        for (int i = 0; i < 8; i++) begin
            it.bs = 4'(i + 2); it.tx = d[i]; sb_q.push_back(it);
        end
        if (par) begin
            it.bs = 4'd10; it.tx = (^d) ^ po; sb_q.push_back(it);
        end
        it.bs = par ? 4'd11 : 4'd10; it.tx = 1'b1; sb_q.push_back(it);
    endtask

    task automatic pop_model();
        sb_t it;
        it     = sb_q.pop_front();
        m_bs   = it.bs;
        m_tx   = it.tx;
        m_busy = 1'b1;
    endtask

    // One clock of stimulus on the 8-bit instance, with model update and checks.
    task automatic cyc(input bit tk, input bit rdy);
        bit exp_done, exp_ack;
        baud_tick   = tk;
        frame_ready = rdy;
        @(negedge clk);
        exp_done = !reset && tk && m_busy && (sb_q.size() == 0);
        exp_ack  = !reset && tk && rdy && (!m_busy || exp_done);
        check("frame_done", int'(frame_done), int'(exp_done));
        check("frame_ack", int'(frame_ack), int'(exp_ack));
        if (frame_ack)  n_ack++;
        if (frame_done) n_done++;
        @(posedge clk);
        #1;
        if (reset) begin
            sb_q.delete();
            m_bs = 4'd0; m_tx = 1'b1; m_busy = 1'b0;
        end else if (exp_ack) begin
            push_frame(data_in, parity_en, parity_odd);
            pop_model();
        end else if (exp_done) begin
            m_bs = 4'd0; m_tx = 1'b1; m_busy = 1'b0;
        end else if (tk && m_busy) begin
            pop_model();
        end
        check("bit_select", int'(bit_select), int'(m_bs));
        check("tx_bit", int'(tx_bit), int'(m_tx));
        check("busy", int'(busy), int'(m_busy));
    endtask

    task automatic run_frame(input vec_t v);
        int  ticks;
        bit  par;
        par         = (PAR_BUILT != 0) && v.pe;
        data_in     = v.data;
        parity_en   = v.pe;
        parity_odd  = v.po;
        repeat (2) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        ticks = 0;
        while (m_busy && ticks < 40) begin
            if (m_bs == 4'd3) begin
                data_in    = ~v.data;
                parity_en  = ~v.pe;
                parity_odd = ~v.po;
            end
            cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
            ticks++;
            if (par && m_bs == 4'd10) check("parity_bit", int'(tx_bit), int'(v.exp_par));
        end
        check("frame_len", ticks, v.exp_len);
    endtask

    initial begin
        int guard, a0, d0;
        bit busy_drop;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 10 + PAR_BUILT, 1'b1};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 10 + PAR_BUILT, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 10 + PAR_BUILT, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 10, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 10 + PAR_BUILT, 1'b0};

        reset = 1'b1; data_in = 8'h00; parity_en = 1'b0; parity_odd = 1'b0;
        baud_tick = 1'b0; frame_ready = 1'b0;
        t2 = 1'b0; r2 = 1'b0; d2 = 5'h00;
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 1'b0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // back-to-back frames with frame_ready held
        data_in = 8'h5A; parity_en = 1'b0; parity_odd = 1'b0;
        a0 = n_ack; d0 = n_done; busy_drop = 1'b0;
        cyc(1'b1, 1'b1);
        guard = 0;
        while ((n_done - d0) < 2 && guard < 100) begin
            cyc(1'b0, 1'b1);
            data_in = 8'($urandom);
            cyc(1'b1, 1'b1);
            if (!busy) busy_drop = 1'b1;
            guard++;
        end
        guard = 0;
        while (m_busy && guard < 40) begin
            cyc(1'b1, 1'b0);
            guard++;
        end
        check("b2b_acks", n_ack - a0, 3);
        check("b2b_dones", n_done - d0, 3);
        check("b2b_busy_gap", int'(busy_drop), 0);

        // reset mid-frame at bit_select 5, with tick and request present
        data_in = 8'hC3;
        cyc(1'b1, 1'b1);
        guard = 0;
        while (m_bs != 4'd5 && guard < 20) begin
            cyc(1'b1, 1'b0);
            guard++;
        end
        check("reached_idx5", int'(m_bs), 5);
        reset = 1'b1;
        cyc(1'b1, 1'b1);
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        run_frame(vecs[0]);

        // 5 data bits, 2 stop bits
        d2 = 5'h1F; r2 = 1'b1; t2 = 1'b1;
        @(negedge clk);
        check("dut2_ack", int'(ack2), 1);
        @(posedge clk); #1;
        r2 = 1'b0; t2 = 1'b0; d2 = 5'h00;
        check("dut2_bs_start", int'(bs2), 1);
        check("dut2_tx_start", int'(tx2), 0);
        for (int k = 1; k <= 8; k++) begin
            t2 = 1'b1;
            @(negedge clk);
            check("dut2_done", int'(done2), (k == 8) ? 1 : 0);
            @(posedge clk); #1;
            t2 = 1'b0;
            check("dut2_bs", int'(bs2), (k < 8) ? k + 1 : 0);
            check("dut2_tx", int'(tx2), 1);
            check("dut2_busy", int'(busy2), (k < 8) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_bit_sequencer.md
TX_BIT_SEQUENCER -- requirements
Module: tx_bit_sequencer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port baud_tick  input  1  one-cycle pulse per bit period.
REQ-006 SHALL have port frame_ready  input  1  frame request, valid with data_in.
REQ-007 SHALL have port data_in  input  DATA_BITS  payload, LSB sent first.
REQ-008 SHALL have port parity_en  input  1  add parity bit to this frame.
REQ-009 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even.
REQ-010 SHALL have port frame_ack  output  1  one-cycle pulse on frame acceptance.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port bit_select  output  4  current bit index.
REQ-013 SHALL have port tx_bit  output  1  serial line level, registered.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when the last stop bit ends.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 bit_select encoding SHALL be: 0 IDLE; 1 START; 2..DATA_BITS+1 data bit 0..DATA_BITS-1; next index PARITY (if sent); following indices stop bit 1..STOP_BITS.
REQ-017 IDLE SHALL accept a frame only in a cycle with frame_ready=1 and baud_tick=1. Acceptance SHALL latch data_in, parity_en and parity_odd, pulse frame_ack, and enter START on the next edge.
REQ-018 Outside IDLE, each state or bit SHALL be held until baud_tick=1, then SHALL advance by one index on that edge.
REQ-019 tx_bit SHALL be 1 in IDLE, 0 in START, the latched data bit in DATA, the parity bit in PARITY, and 1 in STOP.
REQ-020 Parity bit SHALL be XOR of latched data, inverted when the latched parity_odd=1.
REQ-021 PARITY SHALL be skipped (DATA to STOP) when the latched parity_en=0.
REQ-022 On the baud_tick ending the last stop bit, frame_done SHALL pulse for that cycle.
REQ-023 On that same tick, if frame_ready=1, the block SHALL accept back-to-back: frame_ack pulses and the next state is START with no idle bit. Otherwise the next state is IDLE.
REQ-024 frame_ready, data_in, parity_en and parity_odd changes mid-frame SHALL be ignored; a frame in progress SHALL never abort except on reset.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 frame_ready=1 without baud_tick in IDLE SHALL produce no action; the request is held until a tick.
REQ-027 An illegal DATA_BITS or STOP_BITS value SHALL cause an elaboration error.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE, bit_select=0, tx_bit=1, busy=0, frame_ack=0, frame_done=0, and clear the latched data and parity, including mid-frame.
REQ-029 reset SHALL take priority over baud_tick and frame_ready in the same cycle.

Configuration
REQ-030 Macro TX_BIT_SEQ_PARITY_EN defined: PARITY state and parity logic SHALL be compiled in per REQ-020/021.
REQ-031 Macro TX_BIT_SEQ_PARITY_EN undefined: parity_en and parity_odd SHALL remain as ports but be ignored. No PARITY state SHALL exist, and stop indices SHALL follow the data indices directly.

Verification
REQ-032 DATA_BITS=8, STOP_BITS=1, no parity, data 8'hA5, accepted on a tick: tx_bit sequence 0,1,0,1,0,0,1,0,1,1 over 10 ticks; bit_select 1..10; frame_done on tick 10.
REQ-033 Macro defined, parity_en=1, parity_odd=0, data 8'h07: parity bit=1 at bit_select=10; with parity_odd=1 it is 0; stop at index 11.
REQ-034 frame_ready held continuously, 3 frames: frame_ack pulses on the final stop tick of each frame; tx_bit has no idle gap; busy stays 1.
REQ-035 reset asserted at bit_select=5: next edge gives bit_select=0, tx_bit=1, busy=0; a new frame then starts cleanly.
REQ-036 DATA_BITS=5, STOP_BITS=2, data 5'h1F: stop indices 7 and 8; frame_done after the 8th tick.
REQ-037 frame_ready dropped and data_in changed at bit_select=3: transmitted bits match the data latched at acceptance.
